// File: rtl/riscv_definitions.sv
// Shared fetch-side definitions.
//   DATA_WIDTH        : instruction / address width
//   DEFAULT_RESET_PC  : fetch address used when no RESET_PC override is given
//   fetch_entry_t     : one prefetched instruction with its PC
package riscv_definitions;

    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of fetch_entry_t with a synchronous clear.
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : empties the FIFO this edge; push and pop are ignored
//   push, push_data : write one entry (caller guarantees not full)
//   pop             : drop the head entry (caller guarantees not empty)
//   head            : current head entry (undefined contents when empty)
//   count           : number of valid entries
module fetch_fifo
    import riscv_definitions::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     storage_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) storage_q[wr_ptr_q] <= push_data;
    end

    assign head  = storage_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetch requests, buffers the
// in-order responses with their PCs, and presents them to Decode.
//   clk, rst                          : clock, asynchronous active-high reset
//   i_flush, i_jump_addr              : redirect and discard older work
//   o_req_valid, i_req_ready, o_req_addr : memory request channel
//   i_rsp_valid, i_rsp_data           : in-order memory responses
//   o_if_valid, i_if_ready, o_if_inst, o_if_pc : Decode channel
module instr_prefetch_unit
    import riscv_definitions::*;
#(
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_jump_addr,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [DATA_WIDTH-1:0] o_req_addr,
    input  logic                  i_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_rsp_data,
    output logic                  o_if_valid,
    input  logic                  i_if_ready,
    output logic [DATA_WIDTH-1:0] o_if_inst,
    output logic [DATA_WIDTH-1:0] o_if_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   MAX_OUT_W = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_W   = (CNT_W + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    // PC of the next response that will be kept; requests are sequential and
    // responses in order, so a counter replaces a tag FIFO.
    logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_q, discard_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        inflight_total;
    logic                  fifo_valid;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] jump_pc;
    logic                  unused_jump_lsb;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    assign jump_pc         = {i_jump_addr[DATA_WIDTH-1:2], 2'b00};
    assign unused_jump_lsb = ^i_jump_addr[1:0];

    // Reserving FIFO space for every in-flight request means a response can
    // always be accepted; no backpressure exists on the response channel.
    assign inflight_total = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign o_req_valid    = !rst && !i_flush
                            && ({1'b0, outstanding_q} < MAX_OUT_W)
                            && (inflight_total < DEPTH_W);
    assign o_req_addr     = fetch_pc_q;

    assign req_fire   = o_req_valid && i_req_ready;
    // A response with nothing outstanding is illegal and is ignored.
    assign rsp_fire   = i_rsp_valid && (outstanding_q != '0);
    assign push       = rsp_fire && !i_flush && (discard_q == '0);
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && i_if_ready && !i_flush;

    assign push_entry.pc   = rsp_pc_q;
    assign push_entry.inst = i_rsp_data;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        case ({req_fire, rsp_fire})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (push)     rsp_pc_d   = rsp_pc_q + PC_STEP;
        if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CNT_ONE;

        // Everything still in flight after this edge belongs to the old path.
        if (i_flush) begin
            fetch_pc_d = jump_pc;
            rsp_pc_d   = jump_pc;
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (i_flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign o_if_valid = fifo_valid;
    assign o_if_inst  = fifo_valid ? head.inst : '0;
    assign o_if_pc    = fifo_valid ? head.pc   : '0;

    a_rsp_without_request : assert property (
        @(posedge clk) disable iff (rst) !(i_rsp_valid && (outstanding_q == '0))
    ) else $error("instr_prefetch_unit: response with no outstanding request");

endmodule

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic [31:0] i_jump_addr;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [31:0] o_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        o_if_valid;
    logic        i_if_ready;
    logic [31:0] o_if_inst;
    logic [31:0] o_if_pc;

    int checks;
    int errors;

    logic [31:0] exp_q [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    int          cyc;
    int          rsp_lat;
    logic        mem_hold;

    always #5 clk = ~clk;

    instr_prefetch_unit #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_jump_addr (i_jump_addr),
        .o_req_valid (o_req_valid),
        .i_req_ready (i_req_ready),
        .o_req_addr  (o_req_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .o_if_valid  (o_if_valid),
        .i_if_ready  (i_if_ready),
        .o_if_inst   (o_if_inst),
        .o_if_pc     (o_if_pc)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk); #3;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d entries still expected, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Memory model: in-order responses rsp_lat cycles after acceptance.
    initial begin
        i_rsp_valid = 1'b0;
        i_rsp_data  = '0;
        cyc         = 0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                i_rsp_valid = 1'b0;
            end else begin
                if (!mem_hold && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                    i_rsp_valid = 1'b1;
                    i_rsp_data  = inst_of(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    i_rsp_valid = 1'b0;
                end
                if (o_req_valid && i_req_ready) begin
                    pend_addr.push_back(o_req_addr);
                    pend_due.push_back(cyc + rsp_lat);
                end
            end
        end
    end

    // Scoreboard monitor: compares every Decode pop with the next expected PC.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk); #2;
            if (!rst && o_if_valid && i_if_ready && !i_flush) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h, expected no pop", o_if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (o_if_pc !== exp_pc || o_if_inst !== inst_of(exp_pc)) begin
                        errors++;
                        $display("FAIL sb_pop: got pc %h inst %h, expected pc %h inst %h",
                                 o_if_pc, o_if_inst, exp_pc, inst_of(exp_pc));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        i_flush     = 1'b0;
        i_jump_addr = '0;
        i_req_ready = 1'b0;
        i_if_ready  = 1'b0;
        mem_hold    = 1'b0;
        rsp_lat     = 1;

        // Reset state
        repeat (2) @(negedge clk); #3;
        check("rst_req_valid", 32'(o_req_valid), 32'd0);
        check("rst_if_valid",  32'(o_if_valid),  32'd0);
        check("rst_if_inst",   o_if_inst,        32'd0);
        check("rst_if_pc",     o_if_pc,          32'd0);
        check("rst_req_addr",  o_req_addr,       RESET_PC);

        // T1: zero-wait stream, PCs 0,4,8,12 from cycle 2
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        @(negedge clk); rst = 1'b0; i_req_ready = 1'b1; i_if_ready = 1'b1; #3;
        check("t1_req_valid_c0", 32'(o_req_valid), 32'd1);
        check("t1_req_addr_c0",  o_req_addr,       RESET_PC);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 4) i_req_ready = 1'b0;
            #3;
            check($sformatf("t1_if_valid_c%0d", c), 32'(o_if_valid), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5)
                check($sformatf("t1_if_pc_c%0d", c), o_if_pc, 32'((c - 2) * 4));
        end
        wait_drain("t1_drain", 10);

        // T2: Decode stalled, FIFO fills to 4 then drains 0..16
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        @(negedge clk); rst = 1'b1; i_if_ready = 1'b0; #3;
        check("t2_rst_if_valid", 32'(o_if_valid), 32'd0);
        @(negedge clk); rst = 1'b0; i_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("t2_full_req_valid", 32'(o_req_valid), 32'd0);
        check("t2_full_if_valid",  32'(o_if_valid),  32'd1);
        check("t2_full_if_pc",     o_if_pc,          32'h0);
        @(negedge clk); i_if_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); i_req_ready = 1'b0; #3;
        check("t2_stall_req_valid", 32'(o_req_valid), 32'd1);
        check("t2_stall_req_addr",  o_req_addr,       32'h14);
        @(negedge clk); #3;
        check("t2_hold_req_addr",   o_req_addr,       32'h14);
        wait_drain("t2_drain", 10);

        // T3: flush to 0x102 with 2 outstanding; both old responses dropped
        exp_q = '{32'h100, 32'h104};
        @(negedge clk); mem_hold = 1'b1; i_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); i_flush = 1'b1; i_jump_addr = 32'h0000_0102; #3;
        check("t3_flush_req_valid", 32'(o_req_valid), 32'd0);
        @(negedge clk); i_flush = 1'b0; mem_hold = 1'b0; #3;
        check("t3_redirect_addr", o_req_addr, 32'h100);
        check("t3_if_valid",      32'(o_if_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); i_req_ready = 1'b0;
        wait_drain("t3_drain", 10);

        // T4: flush together with a response and a Decode pop (latency 2)
        exp_q = '{32'h200, 32'h204};
        @(negedge clk); rsp_lat = 2; i_if_ready = 1'b0; i_req_ready = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk); i_flush = 1'b1; i_jump_addr = 32'h0000_0200; i_if_ready = 1'b1; #3;
        check("t4_flush_req_valid", 32'(o_req_valid), 32'd0);
        check("t4_pre_if_valid",    32'(o_if_valid),  32'd1);
        check("t4_pre_if_pc",       o_if_pc,          32'h108);
        @(negedge clk); i_flush = 1'b0; #3;
        check("t4_post_if_valid",   32'(o_if_valid),  32'd0);
        @(negedge clk); #3;
        check("t4_discard_if_valid", 32'(o_if_valid), 32'd0);
        @(negedge clk); i_req_ready = 1'b0;
        wait_drain("t4_drain", 12);

        // T5: address wrap after flush to 0xFFFF_FFF8
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        @(negedge clk); rsp_lat = 1; i_flush = 1'b1; i_jump_addr = 32'hFFFF_FFF8;
        @(negedge clk); i_flush = 1'b0; i_req_ready = 1'b1; #3;
        check("t5_req_valid", 32'(o_req_valid), 32'd1);
        check("t5_req_addr",  o_req_addr,       32'hFFFF_FFF8);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); i_req_ready = 1'b0; #3;
        check("t5_wrap_addr", o_req_addr, 32'h4);
        wait_drain("t5_drain", 10);

        // T6: reset mid-operation with requests in flight and FIFO occupied
        @(negedge clk); i_if_ready = 1'b0; i_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_hold = 1'b1; #3;
        check("t6_pre_if_valid", 32'(o_if_valid), 32'd1);
        @(negedge clk); rst = 1'b1; #3;
        check("t6_rst_if_valid",  32'(o_if_valid),  32'd0);
        check("t6_rst_req_valid", 32'(o_req_valid), 32'd0);
        check("t6_rst_if_pc",     o_if_pc,          32'd0);
        check("t6_rst_if_inst",   o_if_inst,        32'd0);
        exp_q = '{32'h0, 32'h4};
        @(negedge clk); rst = 1'b0; mem_hold = 1'b0; i_if_ready = 1'b1; #3;
        check("t6_rel_req_valid", 32'(o_req_valid), 32'd1);
        check("t6_rel_req_addr",  o_req_addr,       RESET_PC);
        check("t6_rel_if_valid",  32'(o_if_valid),  32'd0);
        @(negedge clk);
        @(negedge clk); i_req_ready = 1'b0;
        wait_drain("t6_drain", 10);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
